// File: rtl/life_pkg.sv
// Shared types and B3/S23 rule constants for the Game of Life engine.
package life_pkg;

    typedef enum logic [1:0] {IDLE, EVOLVE, COMMIT} life_state_t;

    localparam int NBR_W = 4;
    localparam logic [NBR_W-1:0] BIRTH_CNT   = 4'd3;
    localparam logic [NBR_W-1:0] SURVIVE_MIN = 4'd2;
    localparam logic [NBR_W-1:0] SURVIVE_MAX = 4'd3;

    function automatic logic cell_next(input logic alive, input logic [NBR_W-1:0] cnt);
        return alive ? (cnt >= SURVIVE_MIN && cnt <= SURVIVE_MAX) : (cnt == BIRTH_CNT);
    endfunction

endpackage

// File: rtl/life_if.sv
// Control/status bus between a host and life_engine.
interface life_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int CNT_W = 16
);
    logic                 load;
    logic [ROWS*COLS-1:0] grid_in;
    logic                 step;
    logic                 start;
    logic                 stop;
    logic [ROWS*COLS-1:0] grid_out;
    logic                 busy;
    logic                 gen_done;
    logic [CNT_W-1:0]     gen_count;
    logic                 stable;
    logic                 empty;

    modport master (
        output load, grid_in, step, start, stop,
        input  grid_out, busy, gen_done, gen_count, stable, empty
    );

    modport slave (
        input  load, grid_in, step, start, stop,
        output grid_out, busy, gen_done, gen_count, stable, empty
    );
endinterface

// File: rtl/life_row_evolve.sv
// Combinational next-row evaluator for one grid row.
// LIFE_WRAP_EN selects toroidal column edges; otherwise edges are dead.
module life_row_evolve
    import life_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] nxt
);
    // Padded bit j+1 holds row bit j; the MSB pad sits left of column 0.
    logic [COLS+1:0] pa, pc, pb;

`ifdef LIFE_WRAP_EN
    assign pa = {above[0], above, above[COLS-1]};
    assign pc = {cur[0],   cur,   cur[COLS-1]};
    assign pb = {below[0], below, below[COLS-1]};
`else
    assign pa = {1'b0, above, 1'b0};
    assign pc = {1'b0, cur,   1'b0};
    assign pb = {1'b0, below, 1'b0};
`endif

    for (genvar i = 0; i < COLS; i++) begin : g_cell
        logic [NBR_W-1:0] cnt;
        assign cnt = NBR_W'(pa[i]) + NBR_W'(pa[i+1]) + NBR_W'(pa[i+2])
                   + NBR_W'(pc[i])                   + NBR_W'(pc[i+2])
                   + NBR_W'(pb[i]) + NBR_W'(pb[i+1]) + NBR_W'(pb[i+2]);
        assign nxt[i] = cell_next(cur[i], cnt);
    end

endmodule

// File: rtl/life_engine.sv
// Row-sequential Game of Life engine: one output row per clock, ROWS+1 cycles per generation.
// Define LIFE_WRAP_EN for toroidal edges; default is a dead boundary.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic reset_n,
    life_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

    life_state_t state, state_nxt;

    // Row r lives at index ROWS-1-r so the flat view matches the bus layout.
    logic [ROWS-1:0][COLS-1:0] grid, shadow;
    logic [RW-1:0]    rcnt, cur_idx;
    logic [COLS-1:0]  above, cur, below, row_nxt;
    logic             run, stop_lat, stable, empty;
    logic [CNT_W-1:0] gen_count;
    logic             same, zero, go_on;

    always_comb begin
        cur_idx = LAST - rcnt;
        cur     = grid[cur_idx];
        above   = '0;
        below   = '0;
        if (rcnt != '0)
            above = grid[cur_idx + RW'(1)];
`ifdef LIFE_WRAP_EN
        else
            above = grid[0];
`endif
        if (rcnt != LAST)
            below = grid[cur_idx - RW'(1)];
`ifdef LIFE_WRAP_EN
        else
            below = grid[LAST];
`endif
    end

    life_row_evolve #(.COLS(COLS)) u_row (
        .above (above),
        .cur   (cur),
        .below (below),
        .nxt   (row_nxt)
    );

    assign same  = (shadow == grid);
    assign zero  = (shadow == '0);
    assign go_on = run && !(stop_lat || bus.stop) && !same && !zero;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.load && (bus.step || bus.start)) state_nxt = EVOLVE;
            EVOLVE:  if (rcnt == LAST) state_nxt = COMMIT;
            COMMIT:  state_nxt = go_on ? EVOLVE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Shadow content is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == EVOLVE) shadow[cur_idx] <= row_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grid      <= '0;
            rcnt      <= '0;
            run       <= 1'b0;
            stop_lat  <= 1'b0;
            gen_count <= '0;
            stable    <= 1'b0;
            empty     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    stop_lat <= 1'b0;
                    rcnt     <= '0;
                    if (bus.load) begin
                        grid      <= bus.grid_in;
                        gen_count <= '0;
                        stable    <= 1'b0;
                        empty     <= (bus.grid_in == '0);
                    end else if (bus.step) begin
                        run <= 1'b0;
                    end else if (bus.start) begin
                        run <= 1'b1;
                    end
                end
                EVOLVE: begin
                    rcnt <= (rcnt == LAST) ? '0 : rcnt + RW'(1);
                    if (bus.stop) stop_lat <= 1'b1;
                end
                COMMIT: begin
                    grid   <= shadow;
                    stable <= same;
                    empty  <= zero;
                    rcnt   <= '0;
                    if (gen_count != '1) gen_count <= gen_count + CNT_W'(1);
                    if (go_on) begin
                        if (bus.stop) stop_lat <= 1'b1;
                    end else begin
                        run      <= 1'b0;
                        stop_lat <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.grid_out  = grid;
    assign bus.busy      = (state != IDLE);
    assign bus.gen_done  = (state == COMMIT);
    assign bus.gen_count = gen_count;
    assign bus.stable    = stable;
    assign bus.empty     = empty;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine (8x8) against a cell-by-cell Life model.
module tb_life_engine;
    localparam int ROWS = 8, COLS = 8, CNT_W = 16, N = ROWS * COLS;
    localparam logic [N-1:0] BLINK = 64'h0000_1010_1000_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0, n_err = 0;

    logic [N-1:0] m_grid;
    int           m_cnt;
    logic         m_stable, m_empty;

    life_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) bus ();
    life_engine #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: count the 8 neighbours of every cell directly.
    function automatic logic [N-1:0] life_model(input logic [N-1:0] g);
        logic [N-1:0] res, t;
        int n, rr, cc;
        logic alive;
        res = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
`ifdef LIFE_WRAP_EN
                        rr = (rr + ROWS) % ROWS;
                        cc = (cc + COLS) % COLS;
`else
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) continue;
`endif
                        t = g >> (N - 1 - (rr * COLS + cc));
                        n += int'(t[0]);
                    end
                end
                t = g >> (N - 1 - (r * COLS + c));
                alive = t[0];
                if (n == 3 || (alive && n == 2))
                    res |= (N'(1) << (N - 1 - (r * COLS + c)));
            end
        end
        return res;
    endfunction

    task automatic chk_status(input string tag);
        chk({tag, ".grid"}, bus.grid_out, m_grid);
        chki({tag, ".count"}, int'(bus.gen_count), m_cnt);
        chk1({tag, ".stable"}, bus.stable, m_stable);
        chk1({tag, ".empty"}, bus.empty, m_empty);
        chk1({tag, ".busy"}, bus.busy, 1'b0);
        chk1({tag, ".done"}, bus.gen_done, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".grid"}, bus.grid_out, '0);
        chki({tag, ".count"}, int'(bus.gen_count), 0);
        chk1({tag, ".busy"}, bus.busy, 1'b0);
        chk1({tag, ".done"}, bus.gen_done, 1'b0);
        chk1({tag, ".stable"}, bus.stable, 1'b0);
        chk1({tag, ".empty"}, bus.empty, 1'b1);
    endtask

    task automatic model_gen();
        logic [N-1:0] nx;
        nx       = life_model(m_grid);
        m_stable = (nx == m_grid);
        m_empty  = (nx == '0);
        m_grid   = nx;
        m_cnt++;
    endtask

    task automatic do_load(input logic [N-1:0] g, input string tag);
        bus.grid_in = g;
        bus.load    = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        m_grid   = g;
        m_cnt    = 0;
        m_stable = 1'b0;
        m_empty  = (g == '0);
        chk_status(tag);
    endtask

    // One single-step generation: grid held through EVOLVE/COMMIT, one gen_done pulse.
    task automatic do_step(input string tag);
        int pulses;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        chk1({tag, ".busy_evolve"}, bus.busy, 1'b1);
        pulses = 0;
        for (int i = 1; i <= ROWS + 1; i++) begin
            pulses += int'(bus.gen_done);
            if (i == 4) chk({tag, ".hold"}, bus.grid_out, m_grid);
            @(negedge clk);
        end
        chki({tag, ".pulses"}, pulses, 1);
        model_gen();
        chk_status(tag);
    endtask

    initial begin
        int   p[3];
        int   pulses;
        logic done;
        bus.load = 0; bus.step = 0; bus.start = 0; bus.stop = 0; bus.grid_in = '0;
        m_grid = '0; m_cnt = 0; m_stable = 0; m_empty = 1;

        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);

        do_load(BLINK, "blink_load");
        do_step("blink");
        chk("blink.const", bus.grid_out, 64'h0000_0038_0000_0000);

        do_load(64'h0000_0000_1000_0000, "lone_load");
        do_step("lone");
        chk1("lone.empty_const", bus.empty, 1'b1);

        do_load(64'hC100_0000_0000_0000, "wrap_load");
        do_step("wrap");
`ifdef LIFE_WRAP_EN
        chk("wrap.const", bus.grid_out, 64'h8080_0000_0000_0080);
`else
        chk("wrap.const", bus.grid_out, '0);
`endif

        // Block still life under free-run: one generation then IDLE.
        do_load(64'h0000_1818_0000_0000, "block_load");
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0; done = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) begin done = 1; break; end
            pulses += int'(bus.gen_done);
            @(negedge clk);
        end
        chk1("block.finished", done, 1'b1);
        chki("block.pulses", pulses, 1);
        model_gen();
        chk_status("block");
        chk1("block.stable_const", bus.stable, 1'b1);

        // Free-run blinker, stop during generation 3, load during busy ignored.
        do_load(BLINK, "run_load");
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0; done = 0; p[0] = 0; p[1] = 0; p[2] = 0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            if (!bus.busy) begin done = 1; break; end
            if (bus.gen_done) begin
                if (pulses < 3) p[pulses] = cyc;
                pulses++;
            end
            bus.load    = (cyc == 3);
            bus.grid_in = (cyc == 3) ? '1 : '0;
            bus.stop    = (pulses == 2 && cyc == p[1] + 4);
            @(negedge clk);
        end
        bus.load = 1'b0; bus.stop = 1'b0;
        chk1("run.finished", done, 1'b1);
        chki("run.pulses", pulses, 3);
        chki("run.gap1", p[1] - p[0], ROWS + 1);
        chki("run.gap2", p[2] - p[1], ROWS + 1);
        model_gen(); model_gen(); model_gen();
        chk_status("run");

        // Random grids, 1..3 single steps each.
        for (int it = 0; it < 12; it++) begin
            logic [N-1:0] g;
            int k;
            g = {$urandom, $urandom};
            if (it % 2 == 0) g &= {$urandom, $urandom};
            do_load(g, "rand_load");
            k = $urandom_range(1, 3);
            for (int s = 0; s < k; s++) do_step("rand");
        end

        // Asynchronous reset while evolving row 4.
        do_load(BLINK, "rst_load");
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        repeat (4) @(negedge clk);
        chk1("rst.busy_before", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset("rst_after");
        do_load({$urandom, $urandom}, "post_load");
        do_step("post");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/life_engine.md
# life_engine

Parametrised, sequential Conway's Game of Life engine for the grid datapath. It holds a ROWS×COLS cell grid in registers and computes one output row per clock. A generation therefore takes ROWS+1 cycles, independent of grid size in the column direction. It supports single-step and free-run modes and tracks generation count. It flags stable (still-life) and extinct grids, and its grid bus layout matches the existing 8×8 flat-vector format so the 64-bit case drops in directly.

## Interface
- ROWS, 8, grid height (≥3)
- COLS, 8, grid width (≥3)
- CNT_W, 16, generation counter width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  load grid_in into grid (honoured in IDLE only)
- grid_in  in  ROWS*COLS  initial grid
- step  in  1  compute exactly one generation (IDLE only)
- start  in  1  free-run until stop, stable or extinct (IDLE only)
- stop  in  1  end free-run after current generation
- grid_out  out  ROWS*COLS  current committed grid
- busy  out  1  high in EVOLVE/COMMIT
- gen_done  out  1  one-cycle pulse in COMMIT cycle
- gen_count  out  CNT_W  generations since last load, saturating
- stable  out  1  last generation equalled its predecessor
- empty  out  1  grid_out is all zero

## Operation
- Cell (r,c) maps to bit ROWS*COLS-1-(r*COLS+c). Row 0 is the top row and occupies the MSBs; column 0 is the MSB of each row.
- Rule B3/S23: a dead cell with exactly 3 live neighbours is born; a live cell with 2 or 3 live neighbours survives; every other cell is dead.
- Out-of-grid neighbours count as dead unless LIFE_WRAP_EN is defined.
- FSM states: IDLE, EVOLVE, COMMIT.
- IDLE, priority load > step > start:
  - load: grid←grid_in, gen_count←0, stable←0, empty←(grid_in==0), stay IDLE.
  - step: clear run flag, go to EVOLVE.
  - start: set run flag, go to EVOLVE.
- EVOLVE: row counter r runs 0..ROWS-1. Each cycle, next row r is written into a shadow buffer, computed from rows r-1, r, r+1 of the unchanged grid. After r=ROWS-1, go to COMMIT.
- COMMIT:
  - grid←shadow.
  - gen_count increments, saturating at 2^CNT_W-1.
  - stable←(shadow==grid), empty←(shadow==0), gen_done=1.
  - Go to EVOLVE if run flag is set, no stop has been latched, stable=0 and empty=0; otherwise go to IDLE and clear the run flag.
- stop is latched whenever asserted in EVOLVE/COMMIT. The current generation always completes. The latch clears on entry to IDLE.
- load, step and start are ignored outside IDLE.

## Timing
- Reset values: grid_out=0, gen_count=0, busy=0, gen_done=0, stable=0, empty=1, state IDLE, run flag 0, stop latch 0.
- Reset asserted mid-EVOLVE aborts immediately to these values; the shadow buffer contents are don't-care.
- load to grid_out: 1 cycle.
- step sampled at edge T: EVOLVE occupies cycles T+1..T+ROWS, COMMIT is T+ROWS+1, and grid_out updates at the end of COMMIT. For ROWS=8 that is 9 cycles.
- Free-run produces one generation every ROWS+1 cycles with no IDLE gap between them.
- busy is high from the first EVOLVE cycle through the COMMIT cycle.
- grid_out is stable throughout EVOLVE.

## Configuration
- LIFE_WRAP_EN defined: toroidal edges. The row above row 0 is row ROWS-1, the column left of column 0 is column COLS-1, and the reverse holds at the opposite edges.
- LIFE_WRAP_EN undefined: fixed dead boundary, with zero padding outside the grid.

## Structure
- Package life_pkg holds:
  - typedef enum life_state_t {IDLE, EVOLVE, COMMIT};
  - the B3/S23 neighbour-count constants.
- Sub-module life_row_evolve is a combinational block: inputs are three COLS-bit rows (above, current, below); output is the next COLS-bit row. Edge handling in it is controlled by LIFE_WRAP_EN.
- life_engine contains the FSM, row counter, grid register, shadow register and status logic.

## Test plan
- Blinker, ROWS=COLS=8: load 64'h0000_1010_1000_0000, then pulse step.
  - At cycle +9: grid_out=64'h0000_0038_0000_0000, gen_done pulses once, gen_count=1, stable=0.
- Block still life: load 64'h0000_1818_0000_0000, then start.
  - After one generation: stable=1, gen_count=1, back to IDLE, busy=0.
- Lone cell: load 64'h0000_0000_1000_0000, then step.
  - Result: grid_out=0, empty=1.
- Wrap row 0: load 64'hC100_0000_0000_0000, then step.
  - With LIFE_WRAP_EN: 64'h8080_0000_0000_0080.
  - Without LIFE_WRAP_EN: 0, empty=1.
- Free-run blinker with stop asserted mid-generation 3.
  - Exactly 3 gen_done pulses, 9 cycles apart, then IDLE with gen_count=3.
  - A load asserted during busy is ignored.
- Reset mid-operation: drop reset_n during EVOLVE row 4.
  - All outputs immediately take reset values.
  - A subsequent load plus step works normally.
